// File: rtl/tx_module_pkg.sv
// Shared UART definitions: FSM state encoding, parity-mode codes and the
// oversampling factor, so the transmitter and receiver agree on the frame.
package tx_module_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/tx_module.sv
// UART transmitter: start bit, NB data bits LSB first, optional parity bit and
// a stop period, all timed by the 16x oversampling tick from the baud generator.
module tx_module
    import tx_module_pkg::*;
#(
    parameter int NB_TXMODULE_DATA  = 8,
    parameter int SB_TXMODULE_TICKS = 16,
    parameter int PARITY_MODE       = PARITY_NONE
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_txmodule_TXSTART,
    input  logic                        i_txmodule_BRGTICKS,
    input  logic [NB_TXMODULE_DATA-1:0] i_txmodule_DIN,
    output logic                        o_txmodule_TX,
    output logic                        o_txmodule_TXDONE,
    output logic                        o_txmodule_BUSY
);

    localparam int NB_BITCNT  = $clog2(NB_TXMODULE_DATA);
    localparam int NB_STOPCNT = $clog2(SB_TXMODULE_TICKS);

    localparam logic [3:0]            LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [NB_BITCNT-1:0]  LAST_BIT  = NB_BITCNT'(NB_TXMODULE_DATA - 1);
    localparam logic [NB_STOPCNT-1:0] LAST_STOP = NB_STOPCNT'(SB_TXMODULE_TICKS - 1);
    localparam bit                    PARITY_EN = (PARITY_MODE != PARITY_NONE);

    tx_state_e                   state_q;
    logic [3:0]                  tick_q;
    logic [NB_STOPCNT-1:0]       stop_q;
    logic [NB_BITCNT-1:0]        bit_q;
    logic [NB_TXMODULE_DATA-1:0] shift_q;
    logic                        parity_q;
    logic                        tx_q;

    // NOTE: every register below is assigned with <= so all of them update
    // from the same pre-edge values; blocking '=' here would create ordering races.
    always_ff @(posedge i_clk) begin
        // NOTE: the shift register is a small flop vector, not a memory, so it
        // is cleared with everything else to give a fully defined reset state.
        if (i_reset) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            stop_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (i_txmodule_TXSTART) begin
                        shift_q  <= i_txmodule_DIN;
                        parity_q <= (PARITY_MODE == PARITY_ODD) ? ~(^i_txmodule_DIN)
                                                                :  (^i_txmodule_DIN);
                        tick_q   <= '0;
                        stop_q   <= '0;
                        bit_q    <= '0;
                        state_q  <= ST_START;
                        tx_q     <= 1'b0;
                    end
                end

                ST_START: begin
                    if (i_txmodule_BRGTICKS) begin
                        if (tick_q == LAST_TICK) begin
                            tick_q  <= '0;
                            state_q <= ST_DATA;
                            tx_q    <= shift_q[0];
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                end

                ST_DATA: begin
                    if (i_txmodule_BRGTICKS) begin
                        if (tick_q == LAST_TICK) begin
                            tick_q  <= '0;
                            shift_q <= shift_q >> 1;
                            if (bit_q == LAST_BIT) begin
                                if (PARITY_EN) begin
                                    state_q <= ST_PARITY;
                                    tx_q    <= parity_q;
                                end else begin
                                    state_q <= ST_STOP;
                                    tx_q    <= 1'b1;
                                end
                            end else begin
                                bit_q <= bit_q + NB_BITCNT'(1);
                                // tx must present the next bit on the same edge the shift happens
                                tx_q  <= shift_q[1];
                            end
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (i_txmodule_BRGTICKS) begin
                        if (tick_q == LAST_TICK) begin
                            tick_q  <= '0;
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                end

                ST_STOP: begin
                    tx_q <= 1'b1;
                    if (i_txmodule_BRGTICKS) begin
                        if (stop_q == LAST_STOP) begin
                            stop_q  <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            stop_q <= stop_q + NB_STOPCNT'(1);
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign o_txmodule_TX     = tx_q;
    assign o_txmodule_TXDONE = (state_q == ST_STOP) && i_txmodule_BRGTICKS && (stop_q == LAST_STOP);
    assign o_txmodule_BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_module.sv
// Scoreboard bench for tx_module: stimulus queues expected frames, a monitor
// decodes the serial line tick by tick and compares against them.
module tb_tx_module;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         exp_len;
        bit         abort;
        bit         gap_chk;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [7:0] din;
    logic [3:0] start;

    logic tx0, tx1, tx2, tx3;
    logic done0, done1, done2, done3;
    logic busy0, busy1, busy2, busy3;

    logic tx_s, done_s, busy_s;
    int   cfg_p;
    int   sel;
    int   tick_per;
    int   tcnt;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   frames_seen = 0;
    int   done_cyc = 0;
    int   start_cyc = 0;

    exp_t exp_q[$];

    // Four configurations: no parity, even, odd, and a 2-stop-bit variant.
    tx_module #(.NB_TXMODULE_DATA(8), .SB_TXMODULE_TICKS(16), .PARITY_MODE(0)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_txmodule_TXSTART(start[0]), .i_txmodule_BRGTICKS(tick),
        .i_txmodule_DIN(din), .o_txmodule_TX(tx0), .o_txmodule_TXDONE(done0), .o_txmodule_BUSY(busy0));
    tx_module #(.NB_TXMODULE_DATA(8), .SB_TXMODULE_TICKS(16), .PARITY_MODE(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_txmodule_TXSTART(start[1]), .i_txmodule_BRGTICKS(tick),
        .i_txmodule_DIN(din), .o_txmodule_TX(tx1), .o_txmodule_TXDONE(done1), .o_txmodule_BUSY(busy1));
    tx_module #(.NB_TXMODULE_DATA(8), .SB_TXMODULE_TICKS(16), .PARITY_MODE(2)) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_txmodule_TXSTART(start[2]), .i_txmodule_BRGTICKS(tick),
        .i_txmodule_DIN(din), .o_txmodule_TX(tx2), .o_txmodule_TXDONE(done2), .o_txmodule_BUSY(busy2));
    tx_module #(.NB_TXMODULE_DATA(8), .SB_TXMODULE_TICKS(32), .PARITY_MODE(0)) u_dut3 (
        .i_clk(clk), .i_reset(rst), .i_txmodule_TXSTART(start[3]), .i_txmodule_BRGTICKS(tick),
        .i_txmodule_DIN(din), .o_txmodule_TX(tx3), .o_txmodule_TXDONE(done3), .o_txmodule_BUSY(busy3));

    always_comb begin
        tx_s   = tx0;
        done_s = done0;
        busy_s = busy0;
        cfg_p  = 0;
        case (sel)
            1: begin tx_s = tx1; done_s = done1; busy_s = busy1; cfg_p = 1; end
            2: begin tx_s = tx2; done_s = done2; busy_s = busy2; cfg_p = 2; end
            3: begin tx_s = tx3; done_s = done3; busy_s = busy3; cfg_p = 0; end
            default: ;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Baud tick: one cycle high every tick_per cycles.
    initial begin
        tick = 1'b0;
        tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tick = (tcnt == 0);
            tcnt = (tcnt + 1 >= tick_per) ? 0 : tcnt + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic p, input int len,
                                input bit ab, input bit gap);
        exp_t e;
        e.data    = d;
        e.par     = p;
        e.exp_len = len;
        e.abort   = ab;
        e.gap_chk = gap;
        exp_q.push_back(e);
    endtask

    task automatic send(input int s, input logic [7:0] d);
        din      = d;
        start[s] = 1'b1;
        step();
        start[s] = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 3000 && frames_seen < n; i++) step();
        check("frames_seen", frames_seen, n);
    endtask

    // Monitor: a falling line starts a frame; the expected waveform is derived
    // from the queued byte and the count of ticks seen since the start bit began.
    initial begin : monitor
        exp_t       e;
        int         m, idx, cyc_in, line_err, busy_err, done_tick, abort_idx;
        logic [7:0] got;
        logic       got_par, exp_tx;
        bit         done_seen, rst_seen;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && tx_s === 1'b0) begin
                start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    for (int i = 0; i < 2000 && tx_s === 1'b0; i++) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    if (e.gap_chk) check("b2b_start_after_done", start_cyc - done_cyc, 2);
                    m = 0; line_err = 0; busy_err = 0; got = '0; got_par = 1'b0;
                    done_seen = 0; rst_seen = 0; cyc_in = 0; done_tick = 0; abort_idx = -1;
                    while (!done_seen && !rst_seen && cyc_in < 2000) begin
                        if (cyc_in > 0) @(negedge clk);
                        cyc_in++;
                        idx = m / 16;
                        if (idx == 0)                       exp_tx = 1'b0;
                        else if (idx <= 8)                  exp_tx = e.data[idx-1];
                        else if (idx == 9 && cfg_p != 0)    exp_tx = e.par;
                        else                                exp_tx = 1'b1;
                        if (tx_s !== exp_tx) line_err++;
                        if (busy_s !== 1'b1) busy_err++;
                        if (tick && (m % 16) == 7) begin
                            if (idx >= 1 && idx <= 8)            got[idx-1] = tx_s;
                            else if (idx == 9 && cfg_p != 0)     got_par    = tx_s;
                        end
                        if (tick) m++;
                        if (rst === 1'b1) begin
                            rst_seen  = 1;
                            abort_idx = idx;
                        end else if (done_s === 1'b1) begin
                            done_seen = 1;
                            done_tick = m;
                            done_cyc  = cyc;
                        end
                    end
                    check("frame_terminated", int'(done_seen || rst_seen), 1);
                    check("aborted_as_expected", int'(rst_seen), int'(e.abort));
                    check("line_waveform_errors", line_err, 0);
                    check("busy_low_in_frame", busy_err, 0);
                    if (rst_seen) begin
                        check("abort_in_data_bit3", abort_idx, 4);
                        @(negedge clk);
                        check("abort_tx_high", tx_s, 1);
                        check("abort_busy_low", busy_s, 0);
                        check("abort_no_txdone", done_s, 0);
                    end else if (done_seen) begin
                        check("rx_data", got, e.data);
                        if (cfg_p != 0) check("rx_parity", got_par, e.par);
                        check("frame_ticks_to_txdone", done_tick, e.exp_len);
                        @(negedge clk);
                        check("post_frame_tx_high", tx_s, 1);
                        check("post_frame_busy_low", busy_s, 0);
                        check("post_frame_txdone_low", done_s, 0);
                    end
                    frames_seen++;
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] loop_bytes [4];
        rst      = 1'b1;
        start    = '0;
        din      = '0;
        sel      = 0;
        tick_per = 1;
        repeat (3) step();
        @(negedge clk);
        check("reset_tx0", tx0, 1);
        check("reset_tx3", tx3, 1);
        check("reset_busy0", busy0, 0);
        check("reset_txdone0", done0, 0);
        step();
        rst = 1'b0;
        step();

        // 8N1, 0xA5, tick every cycle: 160-tick frame
        expect_frame(8'hA5, 1'b0, 160, 0, 0);
        send(0, 8'hA5);
        wait_frames(1);

        // Even and odd parity on 0x07 (three ones): parity bits 1 and 0
        sel = 1;
        expect_frame(8'h07, 1'b1, 176, 0, 0);
        send(1, 8'h07);
        wait_frames(2);
        sel = 2;
        expect_frame(8'h07, 1'b0, 176, 0, 0);
        send(2, 8'h07);
        wait_frames(3);

        // Two stop bits, tick every 4 cycles
        sel      = 3;
        tick_per = 4;
        expect_frame(8'h00, 1'b0, 176, 0, 0);
        send(3, 8'h00);
        wait_frames(4);
        tick_per = 1;
        sel      = 0;
        repeat (4) step();

        // TXSTART held high, DIN changes mid-frame; second frame follows directly
        expect_frame(8'h3C, 1'b0, 160, 0, 0);
        expect_frame(8'hC3, 1'b0, 160, 0, 1);
        din      = 8'h3C;
        start[0] = 1'b1;
        step();
        din = 8'hC3;
        for (int i = 0; i < 400; i++) begin
            step();
            if (busy_s === 1'b0) break;
        end
        step();
        start[0] = 1'b0;
        wait_frames(6);

        // Reset during data bit 3 (cycle 70 of the frame), then a clean frame
        expect_frame(8'h5A, 1'b0, 160, 1, 0);
        send(0, 8'h5A);
        repeat (70) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_frames(7);
        expect_frame(8'h5A, 1'b0, 160, 0, 0);
        send(0, 8'h5A);
        wait_frames(8);

        // Loopback-style decode of corner bytes
        loop_bytes[0] = 8'h00;
        loop_bytes[1] = 8'hFF;
        loop_bytes[2] = 8'h55;
        loop_bytes[3] = 8'h80;
        for (int i = 0; i < 4; i++) begin
            expect_frame(loop_bytes[i], 1'b0, 160, 0, 0);
            send(0, loop_bytes[i]);
            wait_frames(9 + i);
        end

        repeat (20) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
